keyexpand128: RTL and testbench

//  AES-128 key schedule generator. Sits directly upstream of encryptSingleRound.

---
 rtl/keyexpand128.sv | 167 ++++++++++++++++
 tb/tb_keyexpand128.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keyexpand128.sv
// ---------------------------------------------------------------------------
// keyexpand128 -- AES-128 key schedule generator.
//
// Accepts one 128-bit cipher key and streams round keys 0..NUM_ROUNDS over a
// valid/ready handshake. Round key 0 is the cipher key itself. Each later key
// is derived from the previous one in a single cycle, so no key storage is
// needed beyond the current round key.
//
// Ports
//   clk            in   1    system clock, all state on the rising edge
//   rst            in   1    asynchronous, active-low reset
//   key_valid_in   in   1    key_in carries a cipher key this cycle
//   key_in         in   128  cipher key, [127:96]=w0 .. [31:0]=w3, [127:120]=byte 0
//   key_ready_out  out  1    idle and able to accept a key
//   rk_valid_out   out  1    round_key_out is valid
//   rk_ready_in    in   1    downstream takes round_key_out this cycle
//   round_key_out  out  128  current round key, same ordering as key_in
//   round_idx_out  out  4    index of round_key_out, 0..NUM_ROUNDS
//   last_key_out   out  1    valid key is the final one (index NUM_ROUNDS)
//
// All outputs come straight from flops; there is no input-to-output path.
// Only KEY_WIDTH=128 is meaningful: the word slicing below is fixed.
// ---------------------------------------------------------------------------
module keyexpand128 #(
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid_in,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic                 key_ready_out,
  output logic                 rk_valid_out,
  input  logic                 rk_ready_in,
  output logic [KEY_WIDTH-1:0] round_key_out,
  output logic [3:0]           round_idx_out,
  output logic                 last_key_out
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // AES forward S-box, indexed by input byte value.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // GF(2^8) doubling used to step the round constant. 80 wraps to 1B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] rk_q, rk_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           rcon_q, rcon_d;
  logic                 last_q, last_d;

  // ---------------------------------------------------------------------
  // Next round key from the current one.
  //   t   = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  //   w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  // ---------------------------------------------------------------------
  logic [31:0]          w3_rot;
  logic [31:0]          sub_word;
  logic [31:0]          t_word;
  logic [KEY_WIDTH-1:0] next_key;

  // RotWord {a,b,c,d} -> {b,c,d,a}; byte a sits in the top 8 bits.
  assign w3_rot = {rk_q[23:0], rk_q[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[8*gi +: 8] = SBOX[w3_rot[8*gi +: 8]];
    end
  endgenerate

  assign t_word = sub_word ^ {rcon_q, 24'h000000};

  assign next_key[127:96] = rk_q[127:96] ^ t_word;
  assign next_key[95:64]  = rk_q[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = rk_q[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = rk_q[31:0]   ^ next_key[63:32];

  // ---------------------------------------------------------------------
  // Control: state register and next-state logic.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    last_d  = last_q;

    unique case (state_q)
      ST_IDLE: begin
        // key_ready_out is simply "in IDLE", so valid alone completes the handshake.
        if (key_valid_in) begin
          state_d = ST_EMIT;
          rk_d    = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          last_d  = (LAST_IDX == 4'd0);
        end
      end

      ST_EMIT: begin
        if (rk_ready_in) begin
          if (idx_q == LAST_IDX) begin
            // Final key consumed: key and index stay as they were.
            state_d = ST_IDLE;
            last_d  = 1'b0;
          end else begin
            rk_d   = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
            last_d = ((idx_q + 4'd1) == LAST_IDX);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign key_ready_out = (state_q == ST_IDLE);
  assign rk_valid_out  = (state_q == ST_EMIT);
  assign round_key_out = rk_q;
  assign round_idx_out = idx_q;
  assign last_key_out  = last_q;

endmodule

// File: tb/tb_keyexpand128.sv
// ---------------------------------------------------------------------------
// tb_keyexpand128 -- directed bench for the AES-128 key schedule generator.
//
// Expected round keys are the published FIPS-197 A.1 and C.1 expansions.
// A small table of runs (key set, stall point, busy-key injection) is played
// back to back, followed by a hand-written reset-during-emit sequence.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_keyexpand128;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         key_ready_out;
  logic         rk_valid_out;
  logic         rk_ready_in;
  logic [127:0] round_key_out;
  logic [3:0]   round_idx_out;
  logic         last_key_out;

  always #5 clk = ~clk;

  keyexpand128 dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid_in  (key_valid_in),
    .key_in        (key_in),
    .key_ready_out (key_ready_out),
    .rk_valid_out  (rk_valid_out),
    .rk_ready_in   (rk_ready_in),
    .round_key_out (round_key_out),
    .round_idx_out (round_idx_out),
    .last_key_out  (last_key_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] rk_a1 [11];
  logic [127:0] rk_c1 [11];

  typedef struct {
    bit           sel_c1;     // 0: A.1 key set, 1: C.1 key set
    int           stall_idx;  // index at which rk_ready_in drops (-1: never)
    int           stall_n;    // cycles of backpressure
    bit           busy;       // offer busy_key throughout the emit phase
    logic [127:0] busy_key;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [127:0] exp_rk(input bit sel_c1, input int i);
    return sel_c1 ? rk_c1[i] : rk_a1[i];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks one emitted round key at the current sample point.
  task automatic check_key(input int v, input int i);
    $display("[TB] vec %0d idx %0d rk %h valid %0b last %0b",
             v, i, round_key_out, rk_valid_out, last_key_out);
    chk("rk_valid", 128'(rk_valid_out), 128'(1));
    chk("key_ready_busy", 128'(key_ready_out), 128'(0));
    chk("round_idx", 128'(round_idx_out), 128'(i));
    chk("round_key", round_key_out, exp_rk(vecs[v].sel_c1, i));
    chk("last_key", 128'(last_key_out), 128'(i == 10));
  endtask

  // Offers the run's key at the current falling edge and follows all 11 keys.
  // Returns at the falling edge where key_ready_out is back high.
  task automatic stream(input int v);
    chk("key_ready_idle", 128'(key_ready_out), 128'(1));
    key_valid_in = 1'b1;
    key_in       = exp_rk(vecs[v].sel_c1, 0);
    rk_ready_in  = 1'b1;
    @(negedge clk);
    key_valid_in = vecs[v].busy;
    key_in       = vecs[v].busy ? vecs[v].busy_key : 128'h0;
    for (int i = 0; i <= 10; i++) begin
      check_key(v, i);
      if (i == vecs[v].stall_idx) begin
        rk_ready_in = 1'b0;
        repeat (vecs[v].stall_n) begin
          @(negedge clk);
          check_key(v, i);
        end
        rk_ready_in = 1'b1;
      end
      @(negedge clk);
    end
    key_valid_in = 1'b0;
    key_in       = 128'h0;
    $display("[TB] vec %0d done valid %0b ready %0b", v, rk_valid_out, key_ready_out);
    chk("end_valid", 128'(rk_valid_out), 128'(0));
    chk("end_ready", 128'(key_ready_out), 128'(1));
    chk("end_last", 128'(last_key_out), 128'(0));
    chk("end_idx_hold", 128'(round_idx_out), 128'(10));
    chk("end_rk_hold", round_key_out, exp_rk(vecs[v].sel_c1, 10));
  endtask

  initial begin
    rk_a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rk_c1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_c1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_c1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_c1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_c1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_c1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_c1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_c1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_c1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_c1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_c1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vecs[0] = '{1'b0, -1, 0, 1'b0, 128'h0};
    vecs[1] = '{1'b1, -1, 0, 1'b0, 128'h0};
    vecs[2] = '{1'b0,  4, 3, 1'b0, 128'h0};
    vecs[3] = '{1'b1, -1, 0, 1'b1, 128'hffeeddccbbaa99887766554433221100};

    rst          = 1'b0;
    key_valid_in = 1'b0;
    key_in       = 128'h0;
    rk_ready_in  = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    chk("rst_ready", 128'(key_ready_out), 128'(1));
    chk("rst_valid", 128'(rk_valid_out), 128'(0));
    chk("rst_rk", round_key_out, 128'h0);
    chk("rst_idx", 128'(round_idx_out), 128'(0));
    chk("rst_last", 128'(last_key_out), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    // Runs are chained: each starts the cycle key_ready_out returns.
    for (int v = 0; v < 4; v++) stream(v);

    // Reset in the middle of an A.1 run, at index 6.
    key_valid_in = 1'b1;
    key_in       = rk_a1[0];
    @(negedge clk);
    key_valid_in = 1'b0;
    key_in       = 128'h0;
    repeat (6) @(negedge clk);
    check_key(0, 6);
    #2 rst = 1'b0;
    #1;
    $display("[TB] async reset at idx 6");
    chk("mid_rst_valid", 128'(rk_valid_out), 128'(0));
    chk("mid_rst_ready", 128'(key_ready_out), 128'(1));
    chk("mid_rst_rk", round_key_out, 128'h0);
    chk("mid_rst_idx", 128'(round_idx_out), 128'(0));
    chk("mid_rst_last", 128'(last_key_out), 128'(0));
    @(negedge clk);
    // Release reset and offer a fresh key in the same cycle.
    rst = 1'b1;
    stream(1);

    // Nothing further should be emitted with no key offered.
    repeat (3) @(negedge clk);
    $display("[TB] idle tail valid %0b ready %0b", rk_valid_out, key_ready_out);
    chk("tail_valid", 128'(rk_valid_out), 128'(0));
    chk("tail_ready", 128'(key_ready_out), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
